// File: rtl/chip_frame_decoder.sv
// Serial frame decoder: synchronizes a chip_clk/chip_rst/chip_data_in bus into clk,
// samples on chip_clk falling edges and writes 11-bit frames into an 8x8 register file.
module chip_frame_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       chip_clk,
  input  logic       chip_rst,
  input  logic       chip_data_in,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       frame_valid,
  output logic [2:0] frame_addr,
  output logic [7:0] frame_level,
  output logic       frame_abort,
  output logic [7:0] dac_written,
  output logic [15:0] frame_count,
  output logic [7:0] abort_count,
  output logic       chip_in_reset,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t state, state_next;

  logic [1:0]  clk_sync;
  logic [1:0]  rst_sync;
  logic [1:0]  data_sync;
  logic        clk_prev;
  logic        sample;
  logic        s_rst_n;
  logic        s_data;

  logic [10:0] shift_reg;
  logic [3:0]  bit_cnt;
  logic [10:0] frame_word;
  logic [7:0]  rf [0:7];
  logic [15:0] frame_count_q;
  logic [7:0]  abort_count_q;

  logic        chip_reset_evt;
  logic        abort_evt;
  logic        start_evt;
  logic        shift_evt;
  logic        commit_evt;

  // Two-flop synchronizers; chip_clk is only ever treated as data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync  <= 2'b00;
      rst_sync  <= 2'b00;
      data_sync <= 2'b00;
      clk_prev  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], chip_clk};
      rst_sync  <= {rst_sync[0], chip_rst};
      data_sync <= {data_sync[0], chip_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  assign sample  = clk_prev & ~clk_sync[1];
  assign s_rst_n = rst_sync[1];
  assign s_data  = data_sync[1];

  // The 11th bit is still in flight on the commit event, so the frame is assembled
  // from the live sample plus the upper ten bits already shifted in.
  assign frame_word = {s_data, shift_reg[10:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    chip_reset_evt = sample & ~s_rst_n;
    abort_evt      = 1'b0;
    start_evt      = 1'b0;
    shift_evt      = 1'b0;
    commit_evt     = 1'b0;
    if (chip_reset_evt) begin
      state_next = IDLE;
      abort_evt  = (state == SHIFT);
    end else begin
      case (state)
        IDLE: begin
          if (sample && s_rst_n && s_data) state_next = HUNT;
        end
        HUNT: begin
          if (sample && s_rst_n && !s_data) begin
            start_evt  = 1'b1;
            state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (sample && s_rst_n) begin
            shift_evt = 1'b1;
            if (bit_cnt == 4'd10) begin
              commit_evt = 1'b1;
              state_next = COMMIT;
            end
          end
        end
        COMMIT: begin
          state_next = HUNT;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg <= 11'd0;
      bit_cnt   <= 4'd0;
    end else if (start_evt) begin
      bit_cnt <= 4'd0;
    end else if (shift_evt) begin
      shift_reg <= frame_word;
      bit_cnt   <= bit_cnt + 4'd1;
    end
  end

  // Frame results land on the edge into COMMIT, so during the COMMIT cycle
  // frame_valid, frame_addr/level and the register file agree with each other.
  // frame_valid and frame_abort are single-cycle strobes with no ready/backpressure:
  // a consumer must take them in the cycle they are high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      dac_written <= 8'h00;
    end else if (chip_reset_evt) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      dac_written <= 8'h00;
    end else if (commit_evt) begin
      rf[frame_word[2:0]]          <= frame_word[10:3];
      dac_written[frame_word[2:0]] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_valid   <= 1'b0;
      frame_abort   <= 1'b0;
      frame_addr    <= 3'd0;
      frame_level   <= 8'h00;
      frame_count_q <= 16'h0000;
      abort_count_q <= 8'h00;
      chip_in_reset <= 1'b1;
      rd_data       <= 8'h00;
    end else begin
      frame_valid <= commit_evt;
      frame_abort <= abort_evt;
      rd_data     <= rf[rd_addr];
      if (sample) chip_in_reset <= ~s_rst_n;
      if (commit_evt) begin
        frame_addr  <= frame_word[2:0];
        frame_level <= frame_word[10:3];
        if (frame_count_q != 16'hFFFF) frame_count_q <= frame_count_q + 16'd1;
      end
      if (abort_evt && abort_count_q != 8'hFF) abort_count_q <= abort_count_q + 8'd1;
    end
  end

  assign frame_count = frame_count_q;
  assign abort_count = abort_count_q;
  assign dbg_state   = state;

endmodule
